// File: rtl/sensor_pkg.sv
// Shared constants and types for the sensor sample path (transmit and receive).
package sensor_pkg;

  localparam int SENSOR_DATA_W     = 16;
  localparam int SENSOR_FIFO_DEPTH = 8;

  // Wide enough for any gap length in 0..15.
  localparam int GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP
  } tx_state_t;

endpackage : sensor_pkg

// File: rtl/sensor_tx_fifo.sv
// Synchronous first-word-fall-through FIFO: rdata_o always shows the entry at head.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sensor_tx_fifo
  import sensor_pkg::*;
#(
  parameter  int DATA_W = SENSOR_DATA_W,
  parameter  int DEPTH  = SENSOR_FIFO_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  // Protect against a caller pushing into a full or popping an empty FIFO.
  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i  && (count_q != '0);

  // Pointer and occupancy next-state; a simultaneous push and pop leaves count alone.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + PTR_W'(1);
    if (pop_ok)  head_d = head_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; emptied pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_q] <= wdata_i;
  end

  assign rdata_o = mem[head_q];
  assign count_o = count_q;

endmodule : sensor_tx_fifo

// File: rtl/sensor_sample_tx.sv
// Buffers front-end samples and replays them as one-cycle strobes spaced GAP+2 cycles apart.
module sensor_sample_tx
  import sensor_pkg::*;
#(
  parameter  int DATA_W = SENSOR_DATA_W,
  parameter  int DEPTH  = SENSOR_FIFO_DEPTH,
  parameter  int GAP    = 2,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              enable,
  output logic [DATA_W-1:0] sensor_data,
  output logic              data_valid,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [7:0]        drop_count
);

  tx_state_t             state_q, state_d;
  logic [GAP_CNT_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0]     sensor_data_q, sensor_data_d;
  logic                  data_valid_q, data_valid_d;
  logic [7:0]            drop_q;
  logic [DATA_W-1:0]     fifo_rdata;
  logic                  push;
  logic                  pop;

  // Ready comes from the registered count only; a same-cycle pop is not anticipated.
  assign in_ready = (fifo_count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;

  sensor_tx_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(in_data),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count)
  );

  // Transmit sequencing: pop and strobe in IDLE, arm the gap in SEND, count it out in GAP.
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    sensor_data_d = sensor_data_q;
    data_valid_d  = 1'b0;
    pop           = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (enable && (fifo_count != '0)) begin
          pop           = 1'b1;
          sensor_data_d = fifo_rdata;
          data_valid_d  = 1'b1;
          state_d       = TX_SEND;
        end
      end
      TX_SEND: begin
        gap_d   = GAP_CNT_W'(GAP);
        state_d = (GAP > 0) ? TX_GAP : TX_IDLE;
      end
      TX_GAP: begin
        // enable is ignored so a started gap always runs to completion.
        gap_d = gap_q - GAP_CNT_W'(1);
        if (gap_q <= GAP_CNT_W'(1)) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // FSM, gap counter and registered output bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TX_IDLE;
      gap_q         <= '0;
      sensor_data_q <= '0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      sensor_data_q <= sensor_data_d;
      data_valid_q  <= data_valid_d;
    end
  end

  // Saturating count of beats offered while the FIFO was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign sensor_data = sensor_data_q;
  assign data_valid  = data_valid_q;
  assign drop_count  = drop_q;

endmodule : sensor_sample_tx

// File: tb/tb_sensor_sample_tx.sv
// Scoreboard bench for sensor_sample_tx: one instance with GAP=2, one with GAP=0.
module tb_sensor_sample_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  // GAP=2 instance
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          enable = 1'b0;
  logic [DW-1:0] sensor_data;
  logic          data_valid;
  logic [3:0]    fifo_count;
  logic [7:0]    drop_count;

  // GAP=0 instance
  logic [DW-1:0] in_data0 = '0;
  logic          in_valid0 = 1'b0;
  logic          in_ready0;
  logic          enable0 = 1'b0;
  logic [DW-1:0] sensor_data0;
  logic          data_valid0;
  logic [3:0]    fifo_count0;
  logic [7:0]    drop_count0;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  // Scoreboard state for the GAP=2 instance
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic [7:0]    drop_exp = '0;
  int            strobe_cyc[$];

  sensor_sample_tx #(.DATA_W(DW), .DEPTH(DEPTH), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .enable(enable), .sensor_data(sensor_data), .data_valid(data_valid),
    .fifo_count(fifo_count), .drop_count(drop_count)
  );

  sensor_sample_tx #(.DATA_W(DW), .DEPTH(DEPTH), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .enable(enable0), .sensor_data(sensor_data0), .data_valid(data_valid0),
    .fifo_count(fifo_count0), .drop_count(drop_count0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Monitor on the falling edge: pop/compare strobes, then track occupancy, ready and drops.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      drop_exp = '0;
    end else begin
      if (data_valid === 1'b1) begin
        strobe_cyc.push_back(cycle);
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_pulse: sensor_data=%h with nothing queued", sensor_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (sensor_data !== exp_v) begin
            tests_failed++;
            $display("FAIL sample_order: got %h expected %h", sensor_data, exp_v);
          end
        end
      end
      tests_run++;
      if (fifo_count !== 4'(exp_q.size())) begin
        tests_failed++;
        $display("FAIL occupancy: fifo_count=%0d expected %0d", fifo_count, exp_q.size());
      end
      tests_run++;
      if (in_ready !== (exp_q.size() < DEPTH)) begin
        tests_failed++;
        $display("FAIL in_ready: got %b expected %b", in_ready, exp_q.size() < DEPTH);
      end
      tests_run++;
      if (drop_count !== drop_exp) begin
        tests_failed++;
        $display("FAIL drop_count: got %0d expected %0d", drop_count, drop_exp);
      end
      if (in_valid === 1'b1) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(in_data);
        else if (drop_exp != 8'hFF) drop_exp = drop_exp + 8'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    tests_run++;
    if (data_valid !== 1'b0 || sensor_data !== 16'h0 || fifo_count !== 4'd0 ||
        drop_count !== 8'd0 || in_ready !== 1'b1 || data_valid0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: dv=%b data=%h count=%0d drops=%0d ready=%b dv0=%b expected 0,0000,0,0,1,0",
               data_valid, sensor_data, fifo_count, drop_count, in_ready, data_valid0);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    enable   = 1'b1;
    in_data  = 16'h0070;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (fifo_count !== 4'd1 || data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_after_push: count=%0d dv=%b expected 1,0", fifo_count, data_valid);
    end
    step();
    tests_run++;
    if (data_valid !== 1'b1 || sensor_data !== 16'h0070 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL single_pulse: dv=%b data=%h count=%0d expected 1,0070,0", data_valid, sensor_data, fifo_count);
    end
    step();
    tests_run++;
    if (data_valid !== 1'b0 || sensor_data !== 16'h0070) begin
      tests_failed++;
      $display("FAIL single_hold: dv=%b data=%h expected 0,0070", data_valid, sensor_data);
    end
    repeat (4) step();
  endtask

  task automatic test_burst();
    logic ready_low = 1'b0;
    strobe_cyc.delete();
    for (int i = 1; i <= 8; i++) begin
      in_data  = 16'(i);
      in_valid = 1'b1;
      if (in_ready !== 1'b1) ready_low = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (40) step();
    tests_run++;
    if (ready_low !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_ready: in_ready dropped during burst, expected always high");
    end
    tests_run++;
    if (strobe_cyc.size() != 8) begin
      tests_failed++;
      $display("FAIL burst_count: got %0d pulses expected 8", strobe_cyc.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        tests_run++;
        if (strobe_cyc[i] - strobe_cyc[i-1] != 4) begin
          tests_failed++;
          $display("FAIL burst_spacing: pulse %0d spacing %0d expected 4", i, strobe_cyc[i] - strobe_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [9:0] ready_seen = '0;
    enable = 1'b0;
    strobe_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      in_data       = 16'h0101 + 16'(i);
      in_valid      = 1'b1;
      ready_seen[i] = in_ready;
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (ready_seen !== 10'b00_1111_1111) begin
      tests_failed++;
      $display("FAIL overflow_ready_pattern: got %b expected 0011111111", ready_seen);
    end
    tests_run++;
    if (in_ready !== 1'b0 || drop_count !== 8'd2 || fifo_count !== 4'd8) begin
      tests_failed++;
      $display("FAIL overflow_state: ready=%b drops=%0d count=%0d expected 0,2,8", in_ready, drop_count, fifo_count);
    end
    enable = 1'b1;
    repeat (50) step();
    tests_run++;
    if (strobe_cyc.size() != 8 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL overflow_drain: pulses=%0d count=%0d expected 8,0", strobe_cyc.size(), fifo_count);
    end
  endtask

  task automatic test_wrap();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data  = 16'h0200 + 16'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    strobe_cyc.delete();
    // Each push lands on the same edge as a pop, so occupancy must stay at 3.
    for (int k = 0; k < 17; k++) begin
      enable   = 1'b1;
      in_data  = 16'h0203 + 16'(k);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      tests_run++;
      if (data_valid !== 1'b1 || fifo_count !== 4'd3) begin
        tests_failed++;
        $display("FAIL wrap_coincident: iter %0d dv=%b count=%0d expected 1,3", k, data_valid, fifo_count);
      end
      repeat (3) step();
    end
    repeat (20) step();
    tests_run++;
    if (strobe_cyc.size() != 20 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL wrap_total: pulses=%0d count=%0d expected 20,0", strobe_cyc.size(), fifo_count);
    end
  endtask

  task automatic test_gap0_enable();
    logic [DW-1:0] vals[$];
    int            cyc[$];
    logic          stray = 1'b0;
    enable0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data0  = 16'h0300 + 16'(i);
      in_valid0 = 1'b1;
      step();
    end
    in_valid0 = 1'b0;
    tests_run++;
    if (fifo_count0 !== 4'd4) begin
      tests_failed++;
      $display("FAIL gap0_queued: count=%0d expected 4", fifo_count0);
    end
    enable0 = 1'b1;
    for (int n = 0; n < 20 && vals.size() < 2; n++) begin
      step();
      if (data_valid0 === 1'b1) begin
        vals.push_back(sensor_data0);
        cyc.push_back(cycle);
        if (vals.size() == 2) enable0 = 1'b0;
      end
    end
    repeat (8) begin
      step();
      if (data_valid0 !== 1'b0) stray = 1'b1;
    end
    tests_run++;
    if (stray !== 1'b0 || fifo_count0 !== 4'd2) begin
      tests_failed++;
      $display("FAIL gap0_gated: stray=%b count=%0d expected 0,2", stray, fifo_count0);
    end
    enable0 = 1'b1;
    for (int n = 0; n < 20 && vals.size() < 4; n++) begin
      step();
      if (data_valid0 === 1'b1) begin
        vals.push_back(sensor_data0);
        cyc.push_back(cycle);
      end
    end
    tests_run++;
    if (vals.size() != 4) begin
      tests_failed++;
      $display("FAIL gap0_pulses: got %0d pulses expected 4", vals.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (vals[i] !== 16'h0300 + 16'(i)) begin
          tests_failed++;
          $display("FAIL gap0_order: pulse %0d got %h expected %h", i, vals[i], 16'h0300 + 16'(i));
        end
      end
      tests_run++;
      if (cyc[1] - cyc[0] != 2 || cyc[3] - cyc[2] != 2) begin
        tests_failed++;
        $display("FAIL gap0_period: spacings %0d,%0d expected 2,2", cyc[1] - cyc[0], cyc[3] - cyc[2]);
      end
    end
    step();
    tests_run++;
    if (fifo_count0 !== 4'd0 || data_valid0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap0_drained: count=%0d dv=%b expected 0,0", fifo_count0, data_valid0);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data  = 16'h0400 + 16'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    step();  // pop edge, now in SEND
    step();  // now in GAP
    tests_run++;
    if (fifo_count !== 4'd3 || drop_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL reset_mid_setup: count=%0d drops=%0d expected 3,2", fifo_count, drop_count);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (data_valid !== 1'b0 || sensor_data !== 16'h0 || fifo_count !== 4'd0 || drop_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_immediate: dv=%b data=%h count=%0d drops=%0d expected 0,0000,0,0",
               data_valid, sensor_data, fifo_count, drop_count);
    end
    step();
    step();
    strobe_cyc.delete();
    rst_n = 1'b1;
    repeat (20) step();
    tests_run++;
    if (strobe_cyc.size() != 0 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_stale: pulses=%0d count=%0d expected 0,0", strobe_cyc.size(), fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_gap0_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_sensor_sample_tx
